daq_uart_tx: RTL and testbench



---
 rtl/daq_uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 32 +++
 rtl/daq_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_daq_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_uart_pkg.sv
// rtl/daq_uart_pkg.sv - shared types and constants for the DAQ UART transmitter
package daq_uart_pkg;

  // Frame sequencing states of the transmitter
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_RELEASE
  } tx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic TXD_IDLE  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser, async active-low reset to 0
//
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronised output, two clk_i cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // Both stages must stay discrete flops placed close together so the first
  // stage has a full cycle to resolve metastability.
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic meta_q;
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/daq_uart_tx.sv
// rtl/daq_uart_tx.sv - 8N1/8N2 UART transmitter fed by the DAQ ready/loaded handshake
//
// Ports:
//   tx_clk         : transmit clock, all logic on its rising edge
//   reset_n        : asynchronous active-low reset
//   tx_data_ready  : producer has a byte on tx_data (asynchronous, synchronised here)
//   tx_data        : byte to send, stable while tx_data_ready is high
//   tx_data_loaded : byte captured; held until frame done and ready withdrawn
//   txd            : serial line, idle high
//   tx_busy        : high from capture until the end of the last stop bit
module daq_uart_tx
  import daq_uart_pkg::*;
#(
  parameter int CLK_DIV   = 347,
  parameter int STOP_BITS = 1
) (
  input  logic       tx_clk,
  input  logic       reset_n,
  input  logic       tx_data_ready,
  input  logic [7:0] tx_data,
  output logic       tx_data_loaded,
  output logic       txd,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
      $error("daq_uart_tx: CLK_DIV must be in 2..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("daq_uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic                 rdy_s;
  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;     // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 loaded_q, loaded_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;

  sync_2ff u_rdy_sync (
    .clk_i  (tx_clk),
    .rst_ni (reset_n),
    .d_i    (tx_data_ready),
    .q_o    (rdy_s)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= TXD_IDLE;
      loaded_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      loaded_q <= loaded_d;
      busy_q   <= busy_d;
    end
  end

  // txd_d carries the level of the state being entered, so txd stays a
  // registered output that lines up exactly with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    loaded_d = loaded_q;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        txd_d = TXD_IDLE;
        if (rdy_s) begin
          shift_d  = tx_data;
          loaded_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
          txd_d    = 1'b0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          txd_d   = shift_q[0];
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            txd_d   = TXD_IDLE;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            txd_d = shift_q[1];
          end
        end
      end

      ST_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d  = '0;
            busy_d = 1'b0;
            // Loaded may only fall once ready is gone, otherwise the
            // producer would see the same byte accepted twice.
            if (!rdy_s) begin
              loaded_d = 1'b0;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_RELEASE: begin
        txd_d = TXD_IDLE;
        if (!rdy_s) begin
          loaded_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        txd_d   = TXD_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign txd            = txd_q;
  assign tx_data_loaded = loaded_q;
  assign tx_busy        = busy_q;

endmodule

// File: tb/tb_daq_uart_tx.sv
// tb/tb_daq_uart_tx.sv - self-checking bench for daq_uart_tx (8N1 and 8N2 instances)
module tb_daq_uart_tx;

  localparam int CLK_DIV = 4;

  logic       tx_clk;
  logic       reset_n;
  logic       rdy    [2];
  logic [7:0] data   [2];
  logic       loaded [2];
  logic       txd    [2];
  logic       busy   [2];

  int checks;
  int errors;

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  daq_uart_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(1)) dut_1stop (
    .tx_clk         (tx_clk),
    .reset_n        (reset_n),
    .tx_data_ready  (rdy[0]),
    .tx_data        (data[0]),
    .tx_data_loaded (loaded[0]),
    .txd            (txd[0]),
    .tx_busy        (busy[0])
  );

  daq_uart_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(2)) dut_2stop (
    .tx_clk         (tx_clk),
    .reset_n        (reset_n),
    .tx_data_ready  (rdy[1]),
    .tx_data        (data[1]),
    .tx_data_loaded (loaded[1]),
    .txd            (txd[1]),
    .tx_busy        (busy[1])
  );

  // Reference line level at cycle cyc of a frame: slot 0 start, 1..8 data LSB first, then stop.
  function automatic logic model_bit(input logic [7:0] b, input int cyc);
    int slot;
    slot = cyc / CLK_DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic expect_frame(input int k, input logic [7:0] b, input int sb, input string tag);
    int n, len, bad, busy_cnt, slot;
    logic [7:0] got;
    len = (1 + 8 + sb) * CLK_DIV;
    n = 0;
    while (txd[k] !== 1'b0 && n < 2000) begin
      @(negedge tx_clk);
      n++;
    end
    checks++;
    if (txd[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s start: txd=%b, required 0 within 2000 cycles", tag, txd[k]);
      return;
    end
    bad = 0;
    busy_cnt = 0;
    got = '0;
    for (int i = 0; i < len; i++) begin
      slot = i / CLK_DIV;
      if (txd[k] !== model_bit(b, i)) bad++;
      if (busy[k] === 1'b1) busy_cnt++;
      if (slot >= 1 && slot <= 8 && (i % CLK_DIV) == CLK_DIV / 2) got[slot-1] = txd[k];
      @(negedge tx_clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s frame: got byte 0x%h with %0d bad samples, required 0x%h", tag, got, bad, b);
    end
    checks++;
    if (busy_cnt != len) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles, required %0d", tag, busy_cnt, len);
    end
    checks++;
    if (txd[k] !== 1'b1 || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s after_frame: txd=%b busy=%b, required txd=1 busy=0", tag, txd[k], busy[k]);
    end
  endtask

  // DAQ-side producer. hold < 0: drop ready as soon as loaded is seen.
  // hold >= 0: keep ready until busy falls plus hold cycles.
  task automatic offer(input int k, input logic [7:0] b, input int hold, input string tag);
    int n, bad;
    data[k] = b;
    rdy[k]  = 1'b1;
    n = 0;
    do begin
      @(negedge tx_clk);
      n++;
    end while (loaded[k] !== 1'b1 && n < 50);
    checks++;
    if (loaded[k] !== 1'b1 || n != 3) begin
      errors++;
      $display("FAIL %s loaded_latency: loaded=%b after %0d cycles, required 1 after 3", tag, loaded[k], n);
    end
    if (hold >= 0) begin
      n = 0;
      while (busy[k] !== 1'b0 && n < 2000) begin
        @(negedge tx_clk);
        n++;
      end
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge tx_clk);
        if (loaded[k] !== 1'b1 || txd[k] !== 1'b1 || busy[k] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s release_wait: %0d bad cycles, required loaded=1 txd=1 busy=0 throughout", tag, bad);
      end
    end
    rdy[k] = 1'b0;
    n = 0;
    while (loaded[k] !== 1'b0 && n < 2000) begin
      @(negedge tx_clk);
      n++;
    end
    checks++;
    if (loaded[k] !== 1'b0 || (hold >= 0 && (n < 2 || n > 3))) begin
      errors++;
      $display("FAIL %s loaded_fall: loaded=%b after %0d cycles, required 0", tag, loaded[k], n);
    end
  endtask

  task automatic expect_quiet(input int k, input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge tx_clk);
      if (txd[k] !== 1'b1 || loaded[k] !== 1'b0 || busy[k] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s quiet: %0d active cycles, required idle line", tag, bad);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge tx_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (txd[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_txd[%0d]: got %b, required 1", k, txd[k]);
      end
      checks++;
      if (loaded[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_loaded[%0d]: got %b, required 0", k, loaded[k]);
      end
      checks++;
      if (busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy[%0d]: got %b, required 0", k, busy[k]);
      end
    end
    reset_n = 1'b1;
    expect_quiet(0, 5, "post_reset");
  endtask

  task automatic test_basic();
    logic [7:0] b;
    fork
      offer(0, 8'hA5, -1, "basic_a5");
      expect_frame(0, 8'hA5, 1, "basic_a5");
    join
    b = 8'($urandom);
    fork
      offer(0, b, -1, "basic_rand");
      expect_frame(0, b, 1, "basic_rand");
    join
  endtask

  task automatic test_two_stop();
    logic [7:0] b;
    fork
      offer(1, 8'hA5, -1, "stop2_a5");
      expect_frame(1, 8'hA5, 2, "stop2_a5");
    join
    b = 8'($urandom);
    fork
      offer(1, b, -1, "stop2_rand");
      expect_frame(1, b, 2, "stop2_rand");
    join
  endtask

  task automatic test_release();
    logic [7:0] b;
    b = 8'($urandom);
    fork
      offer(0, b, 20, "release");
      expect_frame(0, b, 1, "release");
    join
    expect_quiet(0, 3 * (10 * CLK_DIV), "release_no_repeat");
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    q = '{8'h80, 8'hFF, 8'h81};
    repeat (5) q.push_back(8'($urandom));
    fork
      begin
        foreach (q[i]) offer(0, q[i], -1, $sformatf("b2b_tx%0d", i));
      end
      begin
        foreach (q[i]) expect_frame(0, q[i], 1, $sformatf("b2b_rx%0d", i));
      end
    join
    expect_quiet(0, 100, "b2b_no_extra");
  endtask

  task automatic test_async_reset();
    int n;
    data[0] = 8'h3C;
    rdy[0]  = 1'b1;
    n = 0;
    while (txd[0] !== 1'b0 && n < 50) begin
      @(negedge tx_clk);
      n++;
    end
    checks++;
    if (txd[0] !== 1'b0) begin
      errors++;
      $display("FAIL areset_start: txd=%b, required 0", txd[0]);
    end
    repeat (17) @(negedge tx_clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (txd[0] !== 1'b1 || loaded[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: txd=%b loaded=%b busy=%b, required 1 0 0", txd[0], loaded[0], busy[0]);
    end
    rdy[0] = 1'b0;
    @(negedge tx_clk);
    @(negedge tx_clk);
    reset_n = 1'b1;
    @(negedge tx_clk);
    fork
      offer(0, 8'h3C, -1, "areset_reoffer");
      expect_frame(0, 8'h3C, 1, "areset_reoffer");
    join
  endtask

  task automatic test_short_pulse();
    int bad;
    @(negedge tx_clk);
    #1 rdy[0] = 1'b1;
    #2 rdy[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge tx_clk);
      for (int k = 0; k < 2; k++) begin
        if ($isunknown({txd[k], loaded[k], busy[k]})) bad++;
      end
      if (txd[0] !== 1'b1 || loaded[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL short_pulse: %0d bad cycles, required no frame and no X", bad);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    rdy[0]  = 1'b0;
    rdy[1]  = 1'b0;
    data[0] = '0;
    data[1] = '0;
    @(negedge tx_clk);
    test_reset();
    test_basic();
    test_two_stop();
    test_release();
    test_back_to_back();
    test_async_reset();
    test_short_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
